// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants, types and decode helpers for the
//                instruction-decode stage and its scoreboard.
//                Provides opcode constants, default datapath widths, the
//                ID/EX payload struct, the decode-slot state type and
//                small field-decode functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } d_state_t;

    typedef struct packed {
        logic [5:0]        op;
        logic [5:0]        funct;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    // Architectural destination; 0 means the instruction writes nothing.
    function automatic logic [ADDR_W-1:0] decode_dest(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == OP_RTYPE)
            return instr[15:11];
        else if (op == OP_J || op == OP_BEQ || op == OP_BNE || op == OP_SW)
            return '0;
        else
            return instr[20:16];
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return (op != OP_J);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : id_scoreboard
//  Description : Per-register busy bits for in-flight writers and the
//                RAW/WAW hazard check for the instruction in decode.
//  Ports       : clk/rst        clock, async active-high reset
//                i_rs_*/i_rt_*  source addresses and use flags
//                i_dest         destination of decode instruction (0 = none)
//                i_issue        decode instruction issues this cycle
//                i_wb_valid/addr writeback completing this cycle
//                o_hazard       decode instruction must not issue
//  Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard #(
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int ADDR_W = cpu_pkg::ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic              i_rs_use,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic              i_rt_use,
    input  logic [ADDR_W-1:0] i_dest,
    input  logic              i_issue,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_addr,
    output logic              o_hazard
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_waw_haz;

    // Clear first, then set: a new writer issuing on the same edge as an
    // older writeback to the same register keeps the bit busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_valid)
            w_busy_nxt[i_wb_addr] = 1'b0;
        if (i_issue && (i_dest != '0))
            w_busy_nxt[i_dest] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // A source being written back this cycle is satisfied by the bypass;
    // the destination check ignores writeback so write order is preserved.
    assign w_rs_haz  = i_rs_use && r_busy[i_rs_addr] &&
                       !(i_wb_valid && (i_wb_addr == i_rs_addr));
    assign w_rt_haz  = i_rt_use && r_busy[i_rt_addr] &&
                       !(i_wb_valid && (i_wb_addr == i_rt_addr));
    assign w_waw_haz = r_busy[i_dest];
    assign o_hazard  = w_rs_haz || w_rt_haz || w_waw_haz;

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction-decode stage. Holds one fetched instruction,
//                reads its operands from the register file, stalls on
//                scoreboard hazards and hands decoded operands to execute
//                through a registered valid/ready output. Forwards the
//                writeback port to the register file write port.
//  Ports       : reloj_cucu/reseteate  clock, async active-high reset
//                if_*      fetch handshake and instruction
//                rs_/rt_*  register file read address/data
//                rd_*      register file write port
//                wb_*      writeback from later stages
//                ex_*      registered ID/EX outputs with handshake
//                stall_cnt saturating hazard-stall cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = cpu_pkg::NREGS
)(
    input  logic              reloj_cucu,
    input  logic              reseteate,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] rs_addr,
    output logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_w_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [5:0]        ex_op,
    output logic [5:0]        ex_funct,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [31:0]       stall_cnt
);

    import cpu_pkg::*;

    d_state_t          r_state;
    d_state_t          w_state_nxt;
    logic [31:0]       r_instr;
    id_ex_t            r_ex;
    logic              r_ex_valid;
    logic [31:0]       r_stall_cnt;

    logic              w_full;
    logic [5:0]        w_op;
    logic [ADDR_W-1:0] w_dest;
    logic              w_use_rs;
    logic              w_use_rt;
    logic              w_hazard;
    logic              w_issue;
    logic              w_load;
    logic              w_if_ready;
    logic              w_rs_byp;
    logic              w_rt_byp;
    id_ex_t            w_ex_nxt;

    assign w_full   = (r_state == S_FULL);
    assign w_op     = r_instr[31:26];
    assign w_dest   = decode_dest(r_instr);
    assign w_use_rs = uses_rs(w_op);
    assign w_use_rt = uses_rt(w_op);

    assign rs_addr  = w_full ? r_instr[25:21] : '0;
    assign rt_addr  = w_full ? r_instr[20:16] : '0;

    assign rd_addr   = wb_valid ? wb_addr : '0;
    assign rd_w_data = wb_data;

    id_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk        (reloj_cucu),
        .rst        (reseteate),
        .i_rs_addr  (rs_addr),
        .i_rs_use   (w_use_rs),
        .i_rt_addr  (rt_addr),
        .i_rt_use   (w_use_rt),
        .i_dest     (w_dest),
        .i_issue    (w_issue),
        .i_wb_valid (wb_valid),
        .i_wb_addr  (wb_addr),
        .o_hazard   (w_hazard)
    );

    assign w_issue = w_full && !w_hazard && (!r_ex_valid || ex_ready);

    // Same-cycle writeback of a used source overrides the stale file value.
    assign w_rs_byp = w_use_rs && wb_valid && (wb_addr == rs_addr) && (rs_addr != '0);
    assign w_rt_byp = w_use_rt && wb_valid && (wb_addr == rt_addr) && (rt_addr != '0);

    always_comb begin
        w_ex_nxt        = '0;
        w_ex_nxt.op     = w_op;
        w_ex_nxt.funct  = r_instr[5:0];
        w_ex_nxt.dest   = w_dest;
        w_ex_nxt.rs_val = w_rs_byp ? wb_data : rs_data;
        w_ex_nxt.rt_val = w_rt_byp ? wb_data : rt_data;
        w_ex_nxt.imm    = {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
    end

    // Decode-slot FSM: next state and fetch-side ready.
    always_comb begin
        w_state_nxt = r_state;
        w_if_ready  = 1'b1;
        case (r_state)
            S_EMPTY: begin
                w_if_ready = 1'b1;
                if (if_valid)
                    w_state_nxt = S_FULL;
            end
            S_FULL: begin
                w_if_ready = w_issue;
                if (w_issue && !if_valid)
                    w_state_nxt = S_EMPTY;
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    assign if_ready = w_if_ready;
    assign w_load   = if_valid && w_if_ready;

    always_ff @(posedge reloj_cucu or posedge reseteate) begin
        if (reseteate)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge reloj_cucu or posedge reseteate) begin
        if (reseteate)
            r_instr <= '0;
        else if (w_load)
            r_instr <= if_instr;
    end

    always_ff @(posedge reloj_cucu or posedge reseteate) begin
        if (reseteate) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_ex_nxt;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge reloj_cucu or posedge reseteate) begin
        if (reseteate)
            r_stall_cnt <= '0;
        else if (w_full && w_hazard && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign ex_valid  = r_ex_valid;
    assign ex_op     = r_ex.op;
    assign ex_funct  = r_ex.funct;
    assign ex_dest   = r_ex.dest;
    assign ex_rs_val = r_ex.rs_val;
    assign ex_rt_val = r_ex.rt_val;
    assign ex_imm    = r_ex.imm;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Directed self-checking bench for id_stage. A small register
//                file model answers read ports and absorbs writebacks;
//                expected ID/EX payloads are queued on fetch acceptance and
//                compared when execute consumes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data, rd_w_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_op, ex_funct;
    logic [4:0]  ex_dest;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    id_stage dut (
        .reloj_cucu (clk),
        .reseteate  (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .rd_addr    (rd_addr),
        .rd_w_data  (rd_w_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_op      (ex_op),
        .ex_funct   (ex_funct),
        .ex_dest    (ex_dest),
        .ex_rs_val  (ex_rs_val),
        .ex_rt_val  (ex_rt_val),
        .ex_imm     (ex_imm),
        .stall_cnt  (stall_cnt)
    );

    // Register file model: reg i holds i*11 after reset, reg 0 stays zero.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i * 11);
        end else if (rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_w_data;
        end
    end
    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  dest;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] s_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (ex_valid && ex_ready) begin
            chk("ex_output_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_op",     32'(ex_op),    32'(e.op));
                chk("ex_funct",  32'(ex_funct), 32'(e.funct));
                chk("ex_dest",   32'(ex_dest),  32'(e.dest));
                chk("ex_rs_val", ex_rs_val,     e.rs);
                chk("ex_rt_val", ex_rt_val,     e.rt);
                chk("ex_imm",    ex_imm,        e.imm);
            end
        end
    endtask

    // One clock: sample outputs mid-cycle, then step past the rising edge.
    task automatic cyc();
        logic acc;
        @(negedge clk);
        check_out();
        acc = if_valid && if_ready && !rst;
        @(posedge clk);
        #1;
        if (acc) begin
            q.push_back(pend);
            if_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [4:0] dest,
                         input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] ins;
        ins        = instr;
        pend.op    = ins[31:26];
        pend.funct = ins[5:0];
        pend.dest  = dest;
        pend.rs    = rs;
        pend.rt    = rt;
        pend.imm   = {{16{ins[15]}}, ins[15:0]};
        if_instr   = instr;
        if_valid   = 1'b1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [4:0] dest,
                        input logic [31:0] rs, input logic [31:0] rt);
        drive(instr, dest, rs, rt);
        for (int i = 0; i < 20 && if_valid; i++) cyc();
        chk("accept_timeout", 32'(if_valid), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic wb_cycle(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        cyc();
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h2003_0005;
        ex_ready = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        pend     = '0;

        // Reset held with a pending fetch.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_ready",  32'(if_ready),  32'd1);
        chk("rst_ex_valid",  32'(ex_valid),  32'd0);
        chk("rst_stall_cnt", stall_cnt,      32'd0);
        chk("rst_rs_addr",   32'(rs_addr),   32'd0);
        chk("rst_rt_addr",   32'(rt_addr),   32'd0);
        chk("rst_rd_addr",   32'(rd_addr),   32'd0);
        chk("rst_ex_dest",   32'(ex_dest),   32'd0);
        chk("rst_ex_imm",    ex_imm,         32'd0);
        rst = 1'b0;

        // addi $3,$0,5 then dependent add $4,$3,$3.
        send(32'h2003_0005, 5'd3, 32'd0, 32'd33);
        chk("latency_not_yet", 32'(ex_valid), 32'd0);
        send(32'h0063_2020, 5'd4, 32'd5, 32'd5);
        chk("latency_ex_valid", 32'(ex_valid), 32'd1);
        chk("addi_dest",        32'(ex_dest),  32'd3);
        chk("raw_if_ready_low", 32'(if_ready), 32'd0);
        chk("raw_rs_addr",      32'(rs_addr),  32'd3);
        repeat (3) cyc();
        chk("raw_stall_cnt",    stall_cnt,     32'd3);
        chk("raw_no_issue",     32'(ex_valid), 32'd0);
        wb_valid = 1'b1;
        wb_addr  = 5'd3;
        wb_data  = 32'd5;
        #1;
        chk("wb_rd_addr",   32'(rd_addr), 32'd3);
        chk("wb_rd_w_data", rd_w_data,    32'd5);
        cyc();
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        chk("bypass_issue",     32'(ex_valid), 32'd1);
        chk("bypass_stall_cnt", stall_cnt,     32'd3);
        drain();

        // Backpressure with three back-to-back instructions.
        ex_ready = 1'b0;
        drive(32'hAC45_0008, 5'd0, 32'd22, 32'd55);
        cyc();
        drive(32'h3C00_0123, 5'd0, 32'd0, 32'd0);
        cyc();
        chk("bp_ex_valid", 32'(ex_valid), 32'd1);
        drive(32'h2046_FFFF, 5'd6, 32'd22, 32'd66);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_if_ready_low", 32'(if_ready), 32'd0);
            chk("bp_hold_valid",   32'(ex_valid), 32'd1);
            chk("bp_hold_op",      32'(ex_op),    32'h2B);
            chk("bp_hold_imm",     ex_imm,        32'd8);
            chk("bp_hold_rs",      ex_rs_val,     32'd22);
        end
        ex_ready = 1'b1;
        for (int i = 0; i < 20 && if_valid; i++) cyc();
        chk("bp_accept_timeout", 32'(if_valid), 32'd0);
        drain();
        // Neither sw nor a write to $0 may leave a busy bit behind.
        send(32'h0000_4020, 5'd8, 32'd0, 32'd0);
        send(32'h00A0_4820, 5'd9, 32'd55, 32'd0);
        drain();
        chk("no_false_stall", stall_cnt, 32'd3);

        // Writeback of $7 on the same edge a new $7 writer issues.
        send(32'h2007_0001, 5'd7, 32'd0, 32'd77);
        drain();
        wb_cycle(5'd7, 32'd77);
        drive(32'h2007_0002, 5'd7, 32'd0, 32'd77);
        cyc();
        s_base = stall_cnt;
        wb_cycle(5'd7, 32'd77);
        chk("same_edge_issue", 32'(ex_valid), 32'd1);
        drive(32'h2007_0003, 5'd7, 32'd0, 32'd77);
        cyc();
        repeat (2) cyc();
        chk("set_wins_waw_stall", stall_cnt, s_base + 32'd2);
        wb_cycle(5'd7, 32'd77);
        chk("waw_ignores_wb", stall_cnt, s_base + 32'd3);
        drain();
        chk("waw_final_stall", stall_cnt, s_base + 32'd3);

        // Reset mid-operation: output register and decode slot discarded.
        drive(32'hAC45_0008, 5'd0, 32'd22, 32'd55);
        cyc();
        drive(32'h2007_0004, 5'd7, 32'd0, 32'd77);
        cyc();
        chk("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ex_valid",  32'(ex_valid), 32'd0);
        chk("mid_rst_if_ready",  32'(if_ready), 32'd1);
        chk("mid_rst_stall_cnt", stall_cnt,     32'd0);
        chk("mid_rst_ex_op",     32'(ex_op),    32'd0);
        chk("mid_rst_rs_addr",   32'(rs_addr),  32'd0);
        q.delete();
        if_valid = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        send(32'h2007_0005, 5'd7, 32'd0, 32'd77);
        drain();
        chk("post_rst_no_stall", stall_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage sitting directly upstream of `register_file`. Accepts fetched 32-bit MIPS-style instructions over a valid/ready handshake and drives the register file read addresses (`rs_addr`/`rt_addr`). Captures `rs_data`/`rt_data` into an ID/EX output register for the execute stage, and forwards writeback traffic to the register file's write port (`rd_addr`/`rd_w_data`). A per-register scoreboard stalls RAW/WAW hazards, so execute never receives stale operands.

## Interface
- `DATA_W`, 32, datapath width
- `ADDR_W`, 5, register address width
- `NREGS`, 32, architectural registers; reg 0 hardwired zero
- `reloj_cucu`  in  1  clock, rising edge
- `reseteate`  in  1  reset, asynchronous, active-high
- `if_valid` / `if_ready`  in / out  1  fetch handshake
- `if_instr`  in  32  instruction
- `rs_addr`, `rt_addr`  out  ADDR_W  register file read addresses
- `rs_data`, `rt_data`  in  DATA_W  register file read data, combinational
- `rd_addr`  out  ADDR_W  register file write address; 0 = no write
- `rd_w_data`  out  DATA_W  register file write data
- `wb_valid`  in  1  writeback completes this cycle
- `wb_addr`  in  ADDR_W  writeback destination
- `wb_data`  in  DATA_W  writeback value
- `ex_valid` / `ex_ready`  out / in  1  execute handshake
- `ex_op`, `ex_funct`  out  6  instr[31:26], instr[5:0]
- `ex_dest`  out  ADDR_W  destination reg, 0 if none
- `ex_rs_val`, `ex_rt_val`  out  DATA_W  operands
- `ex_imm`  out  DATA_W  sign-extended instr[15:0]
- `stall_cnt`  out  32  saturating count of hazard-stall cycles

## Operation
- Decode slot D holds one instruction. FSM states:
  - EMPTY: `if_ready`=1. Goes to FULL on an `if_valid` handshake.
  - FULL: `if_ready` = issue.
    - On issue with a concurrent handshake, stays FULL and loads the new instruction.
    - On issue without a handshake, goes to EMPTY.
- Field rules:
  - `rs_addr` = D.instr[25:21].
  - `rt_addr` = D.instr[20:16].
  - Both are 0 when D is EMPTY.
- Destination:
  - opcode 0x00 → instr[15:11].
  - opcode 0x02, 0x04, 0x05, 0x2B → none (0).
  - Otherwise → instr[20:16].
- Sources:
  - rs is used unless opcode is 0x02.
  - rt is used for opcode 0x00, 0x04, 0x05, 0x2B.
- Scoreboard `busy[NREGS-1:0]`; bit 0 is constant 0.
- Hazard when any of these holds:
  - A used source is busy and not being written back this cycle.
  - The destination is busy (WAW), regardless of writeback.
- Issue = D FULL and no hazard and (!`ex_valid` or `ex_ready`). On issue:
  - The output register loads the operands.
  - `busy[dest]` is set when dest ≠ 0.
- Writeback:
  - `rd_addr` = `wb_valid` ? `wb_addr` : 0.
  - `rd_w_data` = `wb_data`.
  - `busy[wb_addr]` is cleared.
- Bypass: when `wb_valid` and `wb_addr` == a used source ≠ 0, the operand is taken from `wb_data` instead of the register file.
- Same-edge set and clear of the same busy bit: set wins.
- The output register holds all `ex_*` stable while `ex_valid` && !`ex_ready`.
- `stall_cnt` increments on each cycle where D is FULL and a hazard blocks issue. It saturates at 0xFFFF_FFFF.

## Timing
- Reset (async, immediate) sets:
  - D EMPTY, `busy`=0, `ex_valid`=0.
  - All `ex_*` data = 0, `stall_cnt`=0, `rs_addr`/`rt_addr`/`rd_addr`=0.
  - `if_ready`=1.
- Reset mid-operation discards D and the output register. No writeback is replayed.
- Latency: instruction accepted at edge N → `ex_valid` after edge N+1 if there is no hazard.
- Throughput: 1 instruction/cycle.
- Writeback is visible to a dependent instruction in D in the same cycle (bypass). That instruction issues at the next edge.
- `if_ready`, `rs_addr`, `rt_addr`, `rd_addr`, `rd_w_data` are combinational. All `ex_*` outputs are registered.

## Structure
- `cpu_pkg` contains:
  - Opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_SW).
  - `NREGS`/`ADDR_W`/`DATA_W` defaults.
  - The `id_ex_t` struct (op, funct, dest, rs_val, rt_val, imm).
- Sub-module `id_scoreboard` owns the busy bits, set/clear priority, and hazard check. Inputs: src addrs + use flags, dest, issue, wb. Output: hazard.

## Test plan
- Reset with `if_valid`=1 → `if_ready`=1 and `ex_valid`=0 while reset is held. The first instruction is accepted after reset release.
- Issue `addi $3,$0,5` (0x20030005) with `ex_ready`=1 → `ex_valid` after one edge with `ex_dest`=3, `ex_imm`=5, `busy[3]`=1.
- Then `add $4,$3,$3` (0x00632020) → stalls; `stall_cnt` increments each cycle. Then pulse `wb_valid` with `wb_addr`=3, `wb_data`=5 → `rd_addr`=3 in that cycle; `ex_rs_val`=`ex_rt_val`=5 at the next edge.
- `ex_ready`=0 for 4 cycles with 3 back-to-back instructions → `ex_*` held stable, `if_ready` drops once D is full, and no instruction is lost or duplicated.
- `sw $5,8($2)` (0xAC450008) → `ex_dest`=0 and no busy bit is set. `lui $0` with dest 0 → no stall, `busy[0]` stays 0.
- Writeback to reg 7 on the same edge as issuing a new writer of reg 7 → `busy[7]`=1 afterwards.
